// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: boundary behaviour selected by MODE.
package counter_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/mod_counter_param.sv
// Up/down modulo counter with runtime terminal value, parallel load, synchronous
// clear and a sticky wrap flag; MODE picks wrap-around or saturation at the bounds.
module mod_counter_param
   import counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MODE  = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] loadVal,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] valOut,
   output logic             zero,
   output logic             tc,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             at_top;
   logic             at_bot;
   logic             at_bound;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] nxt_val;
   logic             nxt_wrap;

   // ">=" rather than "==" so a limit lowered below the count still hits the boundary.
   assign at_top       = (valOut >= limit);
   assign at_bot       = (valOut == '0);
   assign at_bound     = down ? at_bot : at_top;
   assign load_clamped = (loadVal > limit) ? limit : loadVal;

   assign zero = at_bot;
   assign tc   = en & ~clr & ~load & at_bound;

   always_comb begin
      nxt_val  = valOut;
      nxt_wrap = wrapped;
      if (clr) begin
         nxt_val  = '0;
         nxt_wrap = 1'b0;
      end else if (load) begin
         nxt_val = load_clamped;
      end else if (en) begin
         if (!down) begin
            if (at_top) begin
               if (MODE == MODE_SAT) begin
                  nxt_val = limit;
               end else begin
                  nxt_val  = '0;
                  nxt_wrap = 1'b1;
               end
            end else begin
               nxt_val = valOut + ONE;
            end
         end else begin
            // Decrement is unconditional above zero, even when the count exceeds limit.
            if (at_bot) begin
               if (MODE != MODE_SAT) begin
                  nxt_val  = limit;
                  nxt_wrap = 1'b1;
               end
            end else begin
               nxt_val = valOut - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valOut  <= '0;
         wrapped <= 1'b0;
      end else begin
         valOut  <= nxt_val;
         wrapped <= nxt_wrap;
      end
   end

endmodule : mod_counter_param

// File: doc/mod_counter_param.md
MOD_COUNTER_PARAM -- requirements
Module: mod_counter_param

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, counter and limit width in bits (>=2).
REQ-002 Parameter MODE SHALL be: MODE, default 0, boundary behaviour (0 = wrap, 1 = saturate).
REQ-003 Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port clr SHALL be: clr  input  1  synchronous clear of count and sticky flag.
REQ-006 Port en SHALL be: en  input  1  count enable.
REQ-007 Port down SHALL be: down  input  1  direction (0 = up, 1 = down), sampled every cycle.
REQ-008 Port load SHALL be: load  input  1  synchronous parallel load.
REQ-009 Port loadVal SHALL be: loadVal  input  WIDTH  value to load.
REQ-010 Port limit SHALL be: limit  input  WIDTH  runtime terminal value; modulus = limit+1.
REQ-011 Port valOut SHALL be: valOut  output  WIDTH  registered count.
REQ-012 Port zero SHALL be: zero  output  1  combinational, 1 iff valOut == 0.
REQ-013 Port tc SHALL be: tc  output  1  combinational terminal-count pulse.
REQ-014 Port wrapped SHALL be: wrapped  output  1  registered sticky flag, set on any wrap.

Function
REQ-015 Priority SHALL be rst > clr > load > en; inactive cycle holds all state.
REQ-016 clr SHALL set valOut = 0 and wrapped = 0 on the next edge, regardless of load/en.
REQ-017 load SHALL set valOut = min(loadVal, limit) on the next edge; wrapped unchanged.
REQ-018 Up, en=1, valOut < limit: valOut increments by 1 (1-cycle latency).
REQ-019 Up, en=1, valOut >= limit: MODE 0 -> valOut = 0 and wrapped = 1; MODE 1 -> valOut = limit.
REQ-020 Down, en=1, valOut > 0: valOut decrements by 1, even if valOut > limit.
REQ-021 Down, en=1, valOut == 0: MODE 0 -> valOut = limit and wrapped = 1; MODE 1 -> hold at 0.
REQ-022 tc SHALL be en & ~clr & ~load & (down ? valOut == 0 : valOut >= limit), in both modes.
REQ-023 limit SHALL be used as presented each cycle; lowering it below valOut causes the next up-count to take the boundary branch (REQ-019).
REQ-024 limit == 0 SHALL keep valOut at 0 under en in both directions; MODE 0 sets wrapped on each enabled cycle.
REQ-025 Arithmetic SHALL be WIDTH bits; limit = 2^WIDTH-1 gives a full binary counter with no overflow beyond the REQ-019/REQ-021 branches.
REQ-026 Direction changes SHALL take effect on the same edge with no lost or extra counts.

Reset
REQ-027 rst SHALL asynchronously force valOut = 0 and wrapped = 0; zero = 1 and tc = 0 follow combinationally while en = 0.
REQ-028 rst asserted mid-count SHALL override all inputs immediately; counting resumes from 0 on the first edge after release.

Structure
REQ-029 Mode encodings (MODE_WRAP = 0, MODE_SAT = 1) SHALL be defined in shared package counter_pkg; no other shared typedefs are required.
REQ-030 The block SHALL be a single module with no sub-module; the boundary comparator and next-value mux are local logic.

Verification (WIDTH = 4)
REQ-031 MODE 0, limit = 12, up, en held for 14 cycles from reset -> 1..12, 0, 1; tc high at 12; wrapped = 1 after the wrap.
REQ-032 MODE 1, limit = 9, down, load 3 then en for 5 cycles -> 3, 2, 1, 0, 0, 0; tc high at 0; wrapped stays 0.
REQ-033 MODE 0, limit = 5, load 11 -> valOut = 5; up with en -> 0; down with en -> 5, wrapped = 1.
REQ-034 clr, load and en asserted together at valOut = 7 -> valOut = 0, wrapped = 0; then load = 1 with en = 1 -> loadVal applied, no count.
REQ-035 valOut = 8 with limit dropped to 4, up, en -> valOut = 0 and wrapped = 1 (MODE 0) or valOut = 4 (MODE 1).
REQ-036 rst asserted asynchronously mid-cycle at valOut = 6 -> valOut = 0 and wrapped = 0 before the next edge; first count after release gives 1.
